// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback scheduler.
package wb_pkg;

  typedef struct packed {
    logic        fmode;
    logic [4:0]  idx;
    logic [31:0] data;
  } wb_req_t;

  localparam int REQ_ALU    = 0;
  localparam int REQ_FPU    = 1;
  localparam int REQ_LSU    = 2;
  localparam int SB_ENTRIES = 64;

  // Scoreboard slot: freg entries live in the upper half.
  function automatic logic [5:0] sb_index(input logic fmode, input logic [4:0] idx);
    return {fmode, idx};
  endfunction

endpackage

// File: rtl/wb_age_arbiter.sv
// Fixed-priority arbiter with per-requester age counters; a requester denied
// AGE_LIMIT consecutive valid cycles becomes urgent and overrides base priority.
// Optional WBSCHED_PERF_EN adds o_age_max (largest current age).
module wb_age_arbiter #(
  parameter int NREQ      = 3,
  parameter int AGE_LIMIT = 4,
  localparam int AW       = $clog2(AGE_LIMIT + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] i_valid,
  output logic [NREQ-1:0] o_grant
`ifdef WBSCHED_PERF_EN
  ,
  output logic [AW-1:0]   o_age_max
`endif
);

  localparam logic [AW-1:0]   LIMIT   = AW'(AGE_LIMIT);
  localparam logic [AW-1:0]   AGE_ONE = AW'(1);
  localparam logic [NREQ-1:0] VEC_ONE = NREQ'(1);

  logic [AW-1:0]   r_age [NREQ];
  logic [NREQ-1:0] w_urgent;
  logic [NREQ-1:0] w_pick;

  // Urgent requesters are those still valid after AGE_LIMIT denials.
  always_comb begin
    w_urgent = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_urgent[i] = i_valid[i] && (r_age[i] >= LIMIT);
    end
  end

  // Lowest set bit of the chosen pool; grants are suppressed in reset.
  always_comb begin
    w_pick  = (|w_urgent) ? w_urgent : i_valid;
    o_grant = rstn ? (w_pick & (~w_pick + VEC_ONE)) : '0;
  end

  // Age counts consecutive denied valid cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rstn || !i_valid[i] || o_grant[i]) begin
        r_age[i] <= '0;
      end else if (r_age[i] < LIMIT) begin
        r_age[i] <= r_age[i] + AGE_ONE;
      end
    end
  end

`ifdef WBSCHED_PERF_EN
  // Largest age currently held by any requester.
  always_comb begin
    o_age_max = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_age[i] > o_age_max) o_age_max = r_age[i];
    end
  end
`endif

endmodule

// File: rtl/wb_scheduler.sv
// Writeback controller: arbitrates producers onto the single register-file
// write port and tracks pending writes for RAW hazard queries.
// Optional WBSCHED_PERF_EN adds conflict_cnt and max_age outputs.
module wb_scheduler
  import wb_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int AGE_LIMIT = 4,
  localparam int AW       = $clog2(AGE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issue_valid,
  input  logic              issue_fmode,
  input  logic [4:0]        issue_rd,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_fmode,
  input  logic [5*NREQ-1:0] req_reg,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              wenable,
  output logic              wfmode,
  output logic [4:0]        wreg,
  output logic [31:0]       wdata,
  input  logic              chk_fmode1,
  input  logic [4:0]        chk_rreg1,
  input  logic              chk_fmode2,
  input  logic [4:0]        chk_rreg2,
  output logic              busy1,
  output logic              busy2
`ifdef WBSCHED_PERF_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [AW-1:0]     max_age
`endif
);

  wb_req_t                 w_req [NREQ];
  wb_req_t                 w_sel;
  logic                    w_xfer;
  logic [NREQ-1:0]         w_grant;
  logic [SB_ENTRIES-1:0]   r_sb;
  logic [SB_ENTRIES-1:0]   w_sb_next;
  logic                    r_wenable;
  logic                    r_wfmode;
  logic [4:0]              r_wreg;
  logic [31:0]             r_wdata;

`ifdef WBSCHED_PERF_EN
  logic [AW-1:0] w_age_max;
  logic [AW-1:0] r_max_age;
  logic [31:0]   r_conflict_cnt;
`endif

  wb_age_arbiter #(.NREQ(NREQ), .AGE_LIMIT(AGE_LIMIT)) u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .i_valid  (req_valid),
    .o_grant  (w_grant)
`ifdef WBSCHED_PERF_EN
    ,
    .o_age_max(w_age_max)
`endif
  );

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;

  // Unpack requesters and OR-select the one-hot granted entry.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_req[i].fmode = req_fmode[i];
      w_req[i].idx   = req_reg[5*i +: 5];
      w_req[i].data  = req_data[32*i +: 32];
      if (w_grant[i]) w_sel = w_sel | w_req[i];
    end
  end

  // Write stage: greg 0 transfers complete the handshake but never write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wenable <= 1'b0;
      r_wfmode  <= 1'b0;
      r_wreg    <= '0;
      r_wdata   <= '0;
    end else begin
      r_wenable <= w_xfer && (w_sel.fmode || (w_sel.idx != 5'd0));
      if (w_xfer) begin
        r_wfmode <= w_sel.fmode;
        r_wreg   <= w_sel.idx;
        r_wdata  <= w_sel.data;
      end
    end
  end

  assign wenable = r_wenable;
  assign wfmode  = r_wfmode;
  assign wreg    = r_wreg;
  assign wdata   = r_wdata;

  // Scoreboard next state: retire the current write, then apply the new issue
  // so a same-cycle reissue of that register stays pending.
  always_comb begin
    w_sb_next = r_sb;
    if (r_wenable) w_sb_next[sb_index(r_wfmode, r_wreg)] = 1'b0;
    if (issue_valid && (issue_fmode || (issue_rd != 5'd0))) begin
      w_sb_next[sb_index(issue_fmode, issue_rd)] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rstn) r_sb <= '0;
    else       r_sb <= w_sb_next;
  end

  // Busy masks the write in flight, since the file forwards wdata this cycle.
  assign busy1 = r_sb[sb_index(chk_fmode1, chk_rreg1)]
               && !(r_wenable && (r_wfmode == chk_fmode1) && (r_wreg == chk_rreg1))
               && (chk_fmode1 || (chk_rreg1 != 5'd0));
  assign busy2 = r_sb[sb_index(chk_fmode2, chk_rreg2)]
               && !(r_wenable && (r_wfmode == chk_fmode2) && (r_wreg == chk_rreg2))
               && (chk_fmode2 || (chk_rreg2 != 5'd0));

`ifdef WBSCHED_PERF_EN
  // Contention counter and age high-water mark.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_conflict_cnt <= '0;
      r_max_age      <= '0;
    end else begin
      if ($countones(req_valid) >= 2) r_conflict_cnt <= r_conflict_cnt + 32'd1;
      if (w_age_max > r_max_age)      r_max_age      <= w_age_max;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign max_age      = r_max_age;
`endif

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed bench for wb_scheduler with hand-computed expectations.
module tb_wb_scheduler;
  import wb_pkg::*;

  logic        clk;
  logic        rstn;
  logic        issue_valid;
  logic        issue_fmode;
  logic [4:0]  issue_rd;
  logic [2:0]  req_valid;
  logic [2:0]  req_fmode;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wenable;
  logic        wfmode;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        chk_fmode1;
  logic [4:0]  chk_rreg1;
  logic        chk_fmode2;
  logic [4:0]  chk_rreg2;
  logic        busy1;
  logic        busy2;
`ifdef WBSCHED_PERF_EN
  logic [31:0] conflict_cnt;
  logic [2:0]  max_age;
`endif

  int n_cmp = 0;
  int n_err = 0;

  wb_scheduler #(.NREQ(3), .AGE_LIMIT(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .issue_valid (issue_valid),
    .issue_fmode (issue_fmode),
    .issue_rd    (issue_rd),
    .req_valid   (req_valid),
    .req_fmode   (req_fmode),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wenable     (wenable),
    .wfmode      (wfmode),
    .wreg        (wreg),
    .wdata       (wdata),
    .chk_fmode1  (chk_fmode1),
    .chk_rreg1   (chk_rreg1),
    .chk_fmode2  (chk_fmode2),
    .chk_rreg2   (chk_rreg2),
    .busy1       (busy1),
    .busy2       (busy2)
`ifdef WBSCHED_PERF_EN
    ,
    .conflict_cnt(conflict_cnt),
    .max_age     (max_age)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic f,
                         input logic [4:0] r, input logic [31:0] d);
    req_valid[i]        = v;
    req_fmode[i]        = f;
    req_reg[5*i +: 5]   = r;
    req_data[32*i +: 32] = d;
  endtask

  logic [2:0] exp_age [6];

  initial begin
    exp_age = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
    rstn = 1'b0;
    issue_valid = 1'b0; issue_fmode = 1'b0; issue_rd = '0;
    req_valid = 3'b111; req_fmode = '0; req_reg = '0; req_data = '0;
    chk_fmode1 = 1'b0; chk_rreg1 = '0; chk_fmode2 = 1'b0; chk_rreg2 = '0;

    // Reset: grants suppressed, write port cleared.
    tick();
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wen", 32'(wenable), 32'd0);
    chk("rst_wreg", 32'(wreg), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    tick();
    req_valid = '0;
    rstn = 1'b1;

    // Single write from ALU.
    set_req(REQ_ALU, 1'b1, 1'b0, 5'd5, 32'h1234);
    #2;
    chk("single_ready", 32'(req_ready), 32'b001);
    tick();
    set_req(REQ_ALU, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("single_wen", 32'(wenable), 32'd1);
    chk("single_wfmode", 32'(wfmode), 32'd0);
    chk("single_wreg", 32'(wreg), 32'd5);
    chk("single_wdata", wdata, 32'h1234);
    tick();
    #2;
    chk("idle_wen", 32'(wenable), 32'd0);

    // Contention: FPU ages to the limit and is promoted at cycle 4.
    set_req(REQ_ALU, 1'b1, 1'b0, 5'd1, 32'hA0);
    set_req(REQ_FPU, 1'b1, 1'b1, 5'd2, 32'hB0);
    for (int c = 0; c < 6; c++) begin
      #2;
      chk($sformatf("age_ready_c%0d", c), 32'(req_ready), 32'(exp_age[c]));
      if (c == 5) begin
        chk("age_fpu_wfmode", 32'(wfmode), 32'd1);
        chk("age_fpu_wreg", 32'(wreg), 32'd2);
        chk("age_fpu_wdata", wdata, 32'hB0);
      end
      tick();
    end
    req_valid = '0;

    // Scoreboard set by issue, cleared by the matching write.
    issue_valid = 1'b1; issue_fmode = 1'b1; issue_rd = 5'd3;
    chk_fmode1 = 1'b1; chk_rreg1 = 5'd3;
    #2;
    chk("sb_before_set", 32'(busy1), 32'd0);
    tick();
    issue_valid = 1'b0;
    #2;
    chk("sb_busy_set", 32'(busy1), 32'd1);
    set_req(REQ_FPU, 1'b1, 1'b1, 5'd3, 32'h33);
    #2;
    chk("sb_fpu_ready", 32'(req_ready), 32'b010);
    chk("sb_busy_hold", 32'(busy1), 32'd1);
    tick();
    req_valid = '0;
    #2;
    chk("sb_wen_cycle", 32'(wenable), 32'd1);
    chk("sb_busy_masked", 32'(busy1), 32'd0);
    tick();
    #2;
    chk("sb_cleared", 32'(busy1), 32'd0);

    // Same-cycle set and clear of greg7: set wins.
    issue_valid = 1'b1; issue_fmode = 1'b0; issue_rd = 5'd7;
    chk_fmode2 = 1'b0; chk_rreg2 = 5'd7;
    tick();
    issue_valid = 1'b0;
    set_req(REQ_ALU, 1'b1, 1'b0, 5'd7, 32'h77);
    #2;
    chk("ss_busy_before", 32'(busy2), 32'd1);
    chk("ss_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    issue_valid = 1'b1; issue_fmode = 1'b0; issue_rd = 5'd7;
    #2;
    chk("ss_wreg", 32'(wreg), 32'd7);
    chk("ss_busy_masked", 32'(busy2), 32'd0);
    tick();
    issue_valid = 1'b0;
    #2;
    chk("ss_set_wins", 32'(busy2), 32'd1);

    // Zero register handling.
    set_req(REQ_LSU, 1'b1, 1'b0, 5'd0, 32'hFFFF);
    #2;
    chk("z_g0_ready", 32'(req_ready), 32'b100);
    tick();
    set_req(REQ_LSU, 1'b1, 1'b1, 5'd0, 32'h55);
    #2;
    chk("z_g0_wen", 32'(wenable), 32'd0);
    chk("z_f0_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = '0;
    issue_valid = 1'b1; issue_fmode = 1'b0; issue_rd = 5'd0;
    #2;
    chk("z_f0_wen", 32'(wenable), 32'd1);
    chk("z_f0_wfmode", 32'(wfmode), 32'd1);
    chk("z_f0_wreg", 32'(wreg), 32'd0);
    chk("z_f0_wdata", wdata, 32'h55);
    tick();
    issue_valid = 1'b0;
    chk_fmode1 = 1'b0; chk_rreg1 = 5'd0;
    #2;
    chk("z_g0_busy", 32'(busy1), 32'd0);

    // Reset in the cycle after a grant.
    set_req(REQ_ALU, 1'b1, 1'b0, 5'd9, 32'h99);
    #2;
    chk("r_ready", 32'(req_ready), 32'b001);
    tick();
    rstn = 1'b0;
    #2;
    chk("r_ready_in_rst", 32'(req_ready), 32'd0);
    chk("r_wen_staged", 32'(wenable), 32'd1);
    chk("r_wreg_staged", 32'(wreg), 32'd9);
    tick();
    #2;
    chk("r_wen_after", 32'(wenable), 32'd0);
    chk("r_sb_cleared", 32'(busy2), 32'd0);
    chk("r_ready_held", 32'(req_ready), 32'd0);
    rstn = 1'b1;
    #2;
    chk("r_ready_release", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    #2;
    chk("r_post_wen", 32'(wenable), 32'd1);
    chk("r_post_wdata", wdata, 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
